// File: rtl/fmap_raster_tx.sv
// rtl/fmap_raster_tx.sv - pool1 frame store replayed as a raster pixel stream (optional row gaps: TX_ROW_GAP_EN)
module fmap_raster_tx #(
  parameter int WIDTH     = 12,
  parameter int HEIGHT    = 12,
  parameter int DATA_BITS = 12,
  parameter int CHANNELS  = 3,
  parameter int ROW_GAP   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic [CHANNELS*DATA_BITS-1:0] wr_data,
  output logic                          wr_ready,
  input  logic                          out_en,
  output logic                          valid_out,
  output logic [CHANNELS*DATA_BITS-1:0] data_out,
  output logic                          sof_out,
  output logic                          last_out,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(WIDTH);
  localparam int PW    = CHANNELS * DATA_BITS;

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
`ifdef TX_ROW_GAP_EN
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam int GW = $clog2(ROW_GAP + 1);
  logic [GW-1:0] gap_cnt;
`endif

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] col_cnt;
  logic [PW-1:0] mem [DEPTH];

  logic wr_en;
  logic issue;
  logic rd_last;
  logic col_last;

  assign wr_ready = (state == S_FILL);
  assign busy     = (state != S_FILL);
  assign wr_en    = rst_n && (state == S_FILL) && wr_valid;
  assign issue    = (state == S_STREAM) && out_en;
  assign rd_last  = (rd_ptr == AW'(DEPTH - 1));
  assign col_last = (col_cnt == CW'(WIDTH - 1));

  // Frame storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Control FSM: fill the store, then replay it pixel by pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      col_cnt <= '0;
`ifdef TX_ROW_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      case (state)
        S_FILL: begin
          if (wr_valid) begin
            if (wr_ptr == AW'(DEPTH - 1)) begin
              wr_ptr <= '0;
              state  <= S_STREAM;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (out_en) begin
            rd_ptr  <= rd_last ? '0 : rd_ptr + 1'b1;
            col_cnt <= col_last ? '0 : col_cnt + 1'b1;
            if (rd_last) begin
              state <= S_FILL;
            end
`ifdef TX_ROW_GAP_EN
            else if (col_last) begin
              state   <= S_GAP;
              gap_cnt <= '0;
            end
`endif
          end
        end
`ifdef TX_ROW_GAP_EN
        S_GAP: begin
          if (gap_cnt == GW'(ROW_GAP - 1)) begin
            state <= S_STREAM;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
`endif
        default: state <= S_FILL;
      endcase
    end
  end

  // Output register: one cycle behind the issued read; data holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      sof_out    <= 1'b0;
      last_out   <= 1'b0;
      frame_done <= 1'b0;
      data_out   <= '0;
    end else begin
      valid_out  <= issue;
      sof_out    <= issue && (rd_ptr == '0);
      last_out   <= issue && rd_last;
      frame_done <= issue && rd_last;
      if (issue) begin
        data_out <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_fmap_raster_tx.sv
// tb/tb_fmap_raster_tx.sv - scoreboard bench for fmap_raster_tx
module tb_fmap_raster_tx;
  localparam int W  = 12;
  localparam int H  = 12;
  localparam int DB = 12;
  localparam int CH = 3;
  localparam int RG = 2;
  localparam int N  = W * H;
  localparam int PW = CH * DB;
`ifdef TX_ROW_GAP_EN
  localparam int SPAN = N + (H - 1) * RG;
`else
  localparam int SPAN = N;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          out_en = 1'b0;
  logic          valid_out;
  logic [PW-1:0] data_out;
  logic          sof_out;
  logic          last_out;
  logic          frame_done;
  logic          busy;

  fmap_raster_tx #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .CHANNELS(CH), .ROW_GAP(RG)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .out_en(out_en), .valid_out(valid_out), .data_out(data_out), .sof_out(sof_out),
    .last_out(last_out), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] d;
    logic          sof;
    logic          last;
  } px_t;

  px_t           sb[$];
  px_t           exp_px;
  logic [PW-1:0] last_exp_d = '0;
  int            tests = 0;
  int            fails = 0;
  int            rx_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int base, input int i);
    logic [PW-1:0] p;
    for (int k = 0; k < CH; k++) p[k*DB +: DB] = DB'(base + i + k);
    return p;
  endfunction

  // Drives one full frame starting now; expected pixels enter the scoreboard as driven.
  task automatic write_frame(input int base);
    for (int i = 0; i < N; i++) begin
      wr_valid = 1'b1;
      wr_data  = pix(base, i);
      sb.push_back('{pix(base, i), (i == 0), (i == N - 1)});
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
  endtask

  // Waits for the frame's last pixel; reports negedges until sof, span sof..last and valid count.
  task automatic wait_last(output int first, output int span, output int nvalid);
    bit started = 0;
    first = 0; span = 0; nvalid = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!started) first++;
      if (valid_out && sof_out) started = 1;
      if (started) begin
        span++;
        if (valid_out) nvalid++;
      end
      if (valid_out && last_out) return;
    end
    check("timeout_last", 1, 0);
  endtask

  // Output monitor: every valid pixel pops and compares the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        rx_count++;
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          exp_px = sb.pop_front();
          last_exp_d = exp_px.d;
          check("data", data_out, exp_px.d);
          check("sof", sof_out, exp_px.sof);
          check("last", last_out, exp_px.last);
          check("frame_done", frame_done, exp_px.last);
        end
      end else begin
        check("flags_idle", {sof_out, last_out, frame_done}, 3'b000);
      end
    end
  end

  initial begin
    int first, span, nv, prev_en, cnt;
    bit done;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_flags", {sof_out, last_out, frame_done}, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill then stream with out_en held high
    out_en = 1'b1;
    write_frame(0);
    @(negedge clk);
    check("lat_t1_idle", valid_out, 0);
    check("stream_busy", busy, 1);
    check("stream_ready", wr_ready, 0);
    wait_last(first, span, nv);
    check("lat_t2_first", first, 1);
    check("fill_span", span, SPAN);
    check("fill_count", nv, N);

    // Stall: out_en toggles 1,0,1,0 through the stream
    out_en = 1'b0;
    @(posedge clk);
    #1;
    write_frame(100);
    rx_count = 0;
    prev_en = 0;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      out_en = (c % 2 == 0);
      @(negedge clk);
`ifndef TX_ROW_GAP_EN
      check("stall_lag", valid_out, prev_en);
`endif
      prev_en = out_en;
      if (!valid_out) check("stall_hold", data_out, last_exp_d);
      if (valid_out && last_out) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) check("timeout_stall", 1, 0);
    check("stall_count", rx_count, N);

    // Writes while streaming must be ignored
    out_en = 1'b0;
    write_frame(200);
    for (int c = 0; c < 5; c++) begin
      wr_valid = 1'b1;
      wr_data  = {CH{12'hFFF}};
      @(negedge clk);
      check("wds_ready", wr_ready, 0);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    out_en = 1'b1;
    wait_last(first, span, nv);
    check("wds_count", nv, N);

    // Next frame must start at address 0, then a back-to-back frame begins in the frame_done cycle
    write_frame(300);
    wait_last(first, span, nv);
    check("b2b_ready", wr_ready, 1);
    check("b2b_done", frame_done, 1);
    write_frame(400);
    wait_last(first, span, nv);
    check("b2b_count", nv, N);

    // Reset after pixel 50
    write_frame(500);
    cnt = 0;
    done = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (valid_out) cnt++;
      if (cnt == 51) done = 1;
    end
    if (!done) check("timeout_mid", 1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", valid_out, 0);
    check("mid_rst_data", data_out, 0);
    check("mid_rst_flags", {sof_out, last_out, frame_done}, 0);
    check("mid_rst_ready", wr_ready, 1);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    write_frame(600);
    wait_last(first, span, nv);
    check("post_rst_span", span, SPAN);
    check("post_rst_count", nv, N);

    #1;
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
